// File: rtl/img_frame_packer.sv
// Ping-pong packer: streams 8-bit pixels into two 11x11 frame buffers and hands complete frames to the classifier.
// Optional macro PIX_SAT_EN: clamps pixels with the top bit set to 8'h7F and adds the sticky sat_hit output.
module img_frame_packer #(
   parameter int PIX_W = 8,
   parameter int N_PIX = 121
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PIX_W-1:0]         pix_in,
   input  logic                     pix_valid,
   input  logic                     pix_sof,
   output logic                     pix_ready,
   output logic [N_PIX*PIX_W-1:0]   img_source,
   output logic                     valid_top,
   input  logic                     ready_top,
`ifdef PIX_SAT_EN
   output logic                     sat_hit,
`endif
   output logic                     frame_err
);

   localparam int CW = $clog2(N_PIX);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_PIX - 1);

   logic [PIX_W-1:0] buf_q [2][N_PIX];
   logic [1:0]       full_q, full_d;
   logic             wsel_q, wsel_d;
   logic             rsel_q, rsel_d;
   logic [CW-1:0]    pcnt_q, pcnt_d;
   logic             ferr_q, ferr_d;

   logic             accept;
   logic             out_accept;
   logic             frame_done;
   logic [CW-1:0]    widx;
   logic [PIX_W-1:0] wdata;

   // Both handshakes depend only on registered flags, so ready_top never reaches pix_ready combinationally.
   assign pix_ready  = ~full_q[wsel_q];
   assign valid_top  = full_q[rsel_q];
   assign accept     = pix_valid & pix_ready;
   assign out_accept = valid_top & ready_top;
   assign widx       = pix_sof ? '0 : pcnt_q;
   assign frame_done = accept & ~pix_sof & (pcnt_q == LAST_IDX);
   assign frame_err  = ferr_q;

`ifdef PIX_SAT_EN
   logic       sat_pix;
   logic [1:0] sat_q, sat_d;

   assign sat_pix = pix_in[PIX_W-1];
   assign wdata   = sat_pix ? {1'b0, {(PIX_W-1){1'b1}}} : pix_in;
   assign sat_hit = |sat_q;

   // A write at index 0 starts a fresh frame, so it replaces any flag left by abandoned pixels.
   always_comb begin
      sat_d = sat_q;
      if (out_accept) begin
         sat_d[rsel_q] = 1'b0;
      end
      if (accept) begin
         if (widx == '0) begin
            sat_d[wsel_q] = sat_pix;
         end else if (sat_pix) begin
            sat_d[wsel_q] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_q <= '0;
      end else begin
         sat_q <= sat_d;
      end
   end
`else
   assign wdata = pix_in;
`endif

   always_comb begin
      full_d = full_q;
      wsel_d = wsel_q;
      rsel_d = rsel_q;
      pcnt_d = pcnt_q;
      ferr_d = 1'b0;
      if (out_accept) begin
         full_d[rsel_q] = 1'b0;
         rsel_d         = ~rsel_q;
      end
      if (accept) begin
         if (pix_sof) begin
            pcnt_d = CW'(1);
            ferr_d = (pcnt_q != '0);
         end else if (frame_done) begin
            full_d[wsel_q] = 1'b1;
            pcnt_d         = '0;
            wsel_d         = ~wsel_q;
         end else begin
            pcnt_d = pcnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q <= '0;
         wsel_q <= 1'b0;
         rsel_q <= 1'b0;
         pcnt_q <= '0;
         ferr_q <= 1'b0;
      end else begin
         full_q <= full_d;
         wsel_q <= wsel_d;
         rsel_q <= rsel_d;
         pcnt_q <= pcnt_d;
         ferr_q <= ferr_d;
      end
   end

   // The write buffer is never the one being presented while it is full, so the output word stays stable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < N_PIX; k++) begin
               buf_q[b][k] <= '0;
            end
         end
      end else if (accept) begin
         buf_q[wsel_q][widx] <= wdata;
      end
   end

   for (genvar k = 0; k < N_PIX; k++) begin : g_pack
      assign img_source[(N_PIX-k)*PIX_W-1 -: PIX_W] = buf_q[rsel_q][k];
   end

endmodule

// File: tb/tb_img_frame_packer.sv
// Self-checking bench for img_frame_packer: directed scenarios plus a randomized phase,
// all compared against a frame-level queue model of the packer.
module tb_img_frame_packer;

   localparam int PIX_W = 8;
   localparam int N_PIX = 121;
   localparam int W     = N_PIX * PIX_W;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [PIX_W-1:0] pix_in = '0;
   logic             pix_valid = 1'b0;
   logic             pix_sof = 1'b0;
   logic             pix_ready;
   logic [W-1:0]     img_source;
   logic             valid_top;
   logic             ready_top = 1'b0;
   logic             frame_err;
`ifdef PIX_SAT_EN
   logic             sat_hit;
`endif

   always #5 clk = ~clk;

   img_frame_packer #(.PIX_W(PIX_W), .N_PIX(N_PIX)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_sof    (pix_sof),
      .pix_ready  (pix_ready),
      .img_source (img_source),
      .valid_top  (valid_top),
      .ready_top  (ready_top),
`ifdef PIX_SAT_EN
      .sat_hit    (sat_hit),
`endif
      .frame_err  (frame_err)
   );

   typedef struct packed {
      logic       sof;
      logic [7:0] data;
   } pix_t;

   // Reference model: pending pixels to send, completed frames awaiting the classifier,
   // and the frame currently being assembled.
   pix_t         srcQ[$];
   logic [W-1:0] frameQ[$];
   logic [7:0]   part[N_PIX];
   int           cnt;
   logic         errExp;
   logic         partSat;
   logic         satQ[$];

   int nCompared   = 0;
   int nMismatched = 0;
   int nAccepted   = 0;
   int nErrSeen    = 0;

   function automatic logic [7:0] storedValue(input logic [7:0] p);
`ifdef PIX_SAT_EN
      return p[7] ? 8'h7F : p;
`else
      return p;
`endif
   endfunction

   function automatic logic [W-1:0] packFrame();
      logic [W-1:0] v;
      v = '0;
      for (int k = 0; k < N_PIX; k++) begin
         v[(N_PIX-k)*8-1 -: 8] = part[k];
      end
      return v;
   endfunction

   function automatic logic anySat();
      logic s;
      s = partSat;
      foreach (satQ[i]) s = s | satQ[i];
      return s;
   endfunction

   // Every comparison funnels through here so the counters stay consistent.
   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pushFrame(input int len, input logic sofFirst, input logic randomData, input logic [7:0] val);
      pix_t p;
      for (int k = 0; k < len; k++) begin
         p.sof  = (k == 0) ? sofFirst : 1'b0;
         p.data = randomData ? 8'($urandom_range(255)) : val;
         srcQ.push_back(p);
      end
   endtask

   task automatic modelReset();
      frameQ.delete();
      satQ.delete();
      srcQ.delete();
      cnt     = 0;
      errExp  = 1'b0;
      partSat = 1'b0;
   endtask

   // One clock: drive at the falling edge, update the model at the rising edge,
   // compare every output at the next falling edge.
   task automatic applyStimulus(input logic readyIn, input int validPct);
      logic acc;
      logic oacc;
      logic sp;
      pix_t h;
      h = (srcQ.size() > 0) ? srcQ[0] : '0;
      pix_valid = (srcQ.size() > 0) && ($urandom_range(99) < validPct);
      pix_in    = h.data;
      pix_sof   = h.sof;
      ready_top = readyIn;
      acc  = pix_valid && (frameQ.size() < 2);
      oacc = (frameQ.size() > 0) && readyIn;
      @(posedge clk);
      errExp = 1'b0;
      if (oacc) begin
         void'(frameQ.pop_front());
         void'(satQ.pop_front());
      end
      if (acc) begin
         void'(srcQ.pop_front());
         nAccepted++;
         sp = h.data[7];
`ifndef PIX_SAT_EN
         sp = 1'b0;
`endif
         if (h.sof) begin
            errExp  = (cnt != 0);
            part[0] = storedValue(h.data);
            cnt     = 1;
            partSat = sp;
         end else begin
            partSat   = (cnt == 0) ? sp : (partSat | sp);
            part[cnt] = storedValue(h.data);
            cnt++;
            if (cnt == N_PIX) begin
               frameQ.push_back(packFrame());
               satQ.push_back(partSat);
               partSat = 1'b0;
               cnt     = 0;
            end
         end
      end
      @(negedge clk);
      checkOutput("pix_ready", pix_ready, frameQ.size() < 2);
      checkOutput("valid_top", valid_top, frameQ.size() > 0);
      checkOutput("frame_err", frame_err, errExp);
      if (frameQ.size() > 0) begin
         checkOutput("img_source", img_source, frameQ[0]);
      end
`ifdef PIX_SAT_EN
      checkOutput("sat_hit", sat_hit, anySat());
`endif
      if (frame_err) nErrSeen++;
   endtask

   initial begin
      int base;
      int errBase;
      modelReset();
      repeat (3) @(negedge clk);

      // Reset state straight out of power-on reset.
      checkOutput("rst_valid", valid_top, 1'b0);
      checkOutput("rst_ready", pix_ready, 1'b1);
      checkOutput("rst_img", img_source, '0);
      checkOutput("rst_err", frame_err, 1'b0);
      rst = 1'b1;

      // Single ramp frame, classifier always ready.
      for (int k = 0; k < N_PIX; k++) srcQ.push_back({(k == 0), 8'(k)});
      repeat (N_PIX) applyStimulus(1'b1, 100);
      checkOutput("ramp_valid", valid_top, 1'b1);
      checkOutput("ramp_pix0", img_source[W-1 -: 8], 8'h00);
      checkOutput("ramp_pix120", img_source[7:0], 8'h78);
      applyStimulus(1'b1, 100);
      checkOutput("ramp_taken", valid_top, 1'b0);

      // Reset in the middle of a frame, then a fresh frame.
      pushFrame(N_PIX, 1'b1, 1'b1, 8'h00);
      repeat (60) applyStimulus(1'b1, 100);
      rst = 1'b0;
      #1;
      checkOutput("midrst_valid", valid_top, 1'b0);
      checkOutput("midrst_img", img_source, '0);
      checkOutput("midrst_ready", pix_ready, 1'b1);
      checkOutput("midrst_err", frame_err, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      pushFrame(N_PIX, 1'b0, 1'b1, 8'h00);
      repeat (N_PIX) applyStimulus(1'b0, 100);
      checkOutput("fresh_valid", valid_top, 1'b1);
      applyStimulus(1'b1, 100);

      // Back-pressure: three constant frames with the classifier stalled.
      pushFrame(N_PIX, 1'b1, 1'b0, 8'h11);
      pushFrame(N_PIX, 1'b1, 1'b0, 8'h22);
      pushFrame(N_PIX, 1'b1, 1'b0, 8'h33);
      base = nAccepted;
      for (int i = 0; i < 400 && (nAccepted - base) < 2 * N_PIX; i++) applyStimulus(1'b0, 100);
      checkOutput("bp_accepts", nAccepted - base, 2 * N_PIX);
      checkOutput("bp_ready_low", pix_ready, 1'b0);
      checkOutput("bp_head", img_source[W-1 -: 8], 8'h11);
      repeat (5) applyStimulus(1'b0, 100);
      for (int i = 0; i < 200; i++) applyStimulus((i % 10) == 9, 100);
      checkOutput("bp_drained", valid_top, 1'b0);

      // Restart: SOF on pixel 40 abandons the partial frame.
      errBase = nErrSeen;
      pushFrame(40, 1'b1, 1'b1, 8'h00);
      pushFrame(N_PIX, 1'b1, 1'b1, 8'h00);
      repeat (40 + N_PIX) applyStimulus(1'b0, 100);
      checkOutput("restart_pulses", nErrSeen - errBase, 1);
      checkOutput("restart_valid", valid_top, 1'b1);
      applyStimulus(1'b1, 100);

      // Simultaneous output accept and frame completion.
      pushFrame(N_PIX, 1'b1, 1'b1, 8'h00);
      pushFrame(N_PIX, 1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 400 && srcQ.size() > 1; i++) applyStimulus(1'b0, 100);
      checkOutput("simul_prep", pix_ready, 1'b1);
      applyStimulus(1'b1, 100);
      checkOutput("simul_valid", valid_top, 1'b1);
      checkOutput("simul_ready", pix_ready, 1'b1);
      applyStimulus(1'b1, 100);

      // Pixel with the top bit set.
      pushFrame(5, 1'b1, 1'b0, 8'h05);
      srcQ.push_back({1'b0, 8'hC8});
      pushFrame(N_PIX - 6, 1'b0, 1'b0, 8'h06);
      repeat (N_PIX) applyStimulus(1'b0, 100);
`ifdef PIX_SAT_EN
      checkOutput("sat_pixel", img_source[W-1-5*8 -: 8], 8'h7F);
      checkOutput("sat_hit_on", sat_hit, 1'b1);
`else
      checkOutput("sat_pixel", img_source[W-1-5*8 -: 8], 8'hC8);
`endif
      applyStimulus(1'b1, 100);
`ifdef PIX_SAT_EN
      checkOutput("sat_hit_off", sat_hit, 1'b0);
`endif

      // Randomized traffic: gaps, stalls, truncated frames followed by an SOF restart.
      for (int i = 0; i < 3000; i++) begin
         if (srcQ.size() < 20) begin
            if ($urandom_range(9) == 0) begin
               pushFrame(1 + $urandom_range(N_PIX - 2), $urandom_range(1), 1'b1, 8'h00);
               pushFrame(N_PIX, 1'b1, 1'b1, 8'h00);
            end else begin
               pushFrame(N_PIX, $urandom_range(1), 1'b1, 8'h00);
            end
         end
         applyStimulus($urandom_range(1), 80);
      end
      for (int i = 0; i < 600 && (srcQ.size() > 0 || frameQ.size() > 0); i++) applyStimulus(1'b1, 100);
      applyStimulus(1'b1, 100);
      checkOutput("final_valid", valid_top, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
